// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg
// Shared definitions for the two-port LSU arbiter:
//   - memory map region bounds (DMEM, OUT, IN) on the low 12 address bits
//   - byte_num codes for byte, half and word accesses
//   - request/response record types
//   - is_legal(): byte code, alignment and memory map check of one request
package lsu_arb_pkg;

    localparam int LSU_ADDR_W = 32;
    localparam int LSU_DATA_W = 32;

    localparam logic [11:0] DMEM_BASE  = 12'h000;
    localparam logic [11:0] DMEM_LIMIT = 12'h7FF;
    localparam logic [11:0] OUT_BASE   = 12'h800;
    localparam logic [11:0] OUT_LIMIT  = 12'h8AF;
    localparam logic [11:0] IN_BASE    = 12'h900;
    localparam logic [11:0] IN_LIMIT   = 12'h91F;

    localparam logic [3:0] BN_BYTE = 4'b0001;
    localparam logic [3:0] BN_HALF = 4'b0011;
    localparam logic [3:0] BN_WORD = 4'b1111;

    typedef struct packed {
        logic                  we;
        logic [3:0]            byte_num;
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
    } lsu_req_t;

    typedef struct packed {
        logic                  id;
        logic                  err;
        logic [LSU_DATA_W-1:0] rdata;
    } lsu_rsp_t;

    function automatic logic in_range(input logic [11:0] off,
                                      input logic [11:0] base,
                                      input logic [11:0] limit);
        return (off >= base) && (off <= limit);
    endfunction

    function automatic logic is_legal(input lsu_req_t req);
        logic [11:0] off;
        logic        bn_ok;
        logic        align_ok;
        logic        high_ok;
        logic        region_ok;
        off   = req.addr[11:0];
        bn_ok = (req.byte_num == BN_BYTE) || (req.byte_num == BN_HALF) ||
                (req.byte_num == BN_WORD);
        case (req.byte_num)
            BN_HALF: align_ok = ~req.addr[0];
            BN_WORD: align_ok = (req.addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        high_ok   = (req.addr[LSU_ADDR_W-1:12] == '0);
        // The IN window is read-only: a store there is rejected.
        region_ok = in_range(off, DMEM_BASE, DMEM_LIMIT) ||
                    in_range(off, OUT_BASE, OUT_LIMIT) ||
                    (in_range(off, IN_BASE, IN_LIMIT) && !req.we);
        return bn_ok && align_ok && high_ok && region_ok;
    endfunction

endpackage

// File: rtl/lsu_arb_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter with grant lock.
//   valid      : per-port request valid
//   lock       : per-port request to keep the grant
//   rr_ptr     : port favoured when both are valid
//   last_grant : port granted most recently
//   grant      : one-hot grant, or zero when nothing is valid
//   hold       : grant came from the lock path (pointer must not move)
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic [1:0] lock,
    input  logic       rr_ptr,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       hold
);

    always_comb begin
        grant = 2'b00;
        hold  = 1'b0;
        if (valid[last_grant] && lock[last_grant]) begin
            grant[last_grant] = 1'b1;
            hold              = 1'b1;
        end else begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant[rr_ptr] = 1'b1;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/lsu_arb.sv
// lsu_arb
// Arbiter and sequencer between two requesters (port 0 core, port 1 debug
// loader) and a single LSU port. One request is accepted per cycle, checked
// for legality, issued to the LSU from a registered issue stage and answered
// with a tagged one-cycle response two edges after acceptance.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   req_*_i / req_ready_o: per-port request channel
//   rsp_*_o              : response (valid, id, err, rdata), never stalled
//   lsu_*_o              : LSU access driven from the issue register
//   lsu_ld_data_i        : LSU load data, combinational from the LSU
//
// Handshake: a request on port i transfers at a rising edge where
// req_valid_i[i] and req_ready_o[i] are both high. req_ready_o is a one-hot
// grant that depends on the current valid/lock inputs and is only raised for
// a valid port, so at most one transfer happens per edge. A requester keeps
// its request stable until it sees ready. Responses have no ready: rsp_valid_o
// is high for exactly one cycle per accepted request, in acceptance order.
module lsu_arb
    import lsu_arb_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [1:0]             req_we_i,
    input  logic [1:0]             req_lock_i,
    input  logic [1:0][3:0]        req_byte_num_i,
    input  logic [1:0][ADDR_W-1:0] req_addr_i,
    input  logic [1:0][DATA_W-1:0] req_wdata_i,
    output logic                   rsp_valid_o,
    output logic                   rsp_id_o,
    output logic                   rsp_err_o,
    output logic [DATA_W-1:0]      rsp_rdata_o,
    output logic                   lsu_sten_o,
    output logic [3:0]             lsu_byte_num_o,
    output logic [ADDR_W-1:0]      lsu_addr_o,
    output logic [DATA_W-1:0]      lsu_st_data_o,
    input  logic [DATA_W-1:0]      lsu_ld_data_i
);

    // Arbitration state
    logic       rr_ptr_q;
    logic       last_grant_q;
    logic [1:0] grant;
    logic       hold;
    logic       sel;
    logic       accept;
    lsu_req_t   acc_req;

    // Issue stage
    logic       iss_valid_q;
    logic       iss_id_q;
    logic       iss_legal_q;
    lsu_req_t   iss_req_q;

    // Response stage
    logic       rsp_valid_q;
    lsu_rsp_t   rsp_q;

    rr_arb2 u_rr_arb2 (
        .valid      (req_valid_i),
        .lock       (req_lock_i),
        .rr_ptr     (rr_ptr_q),
        .last_grant (last_grant_q),
        .grant      (grant),
        .hold       (hold)
    );

    // No request may be taken while reset is held.
    assign req_ready_o = rst_ni ? grant : 2'b00;
    assign sel         = grant[1];
    assign accept      = |req_ready_o;

    always_comb begin
        acc_req.we       = req_we_i[sel];
        acc_req.byte_num = req_byte_num_i[sel];
        acc_req.addr     = req_addr_i[sel];
        acc_req.wdata    = req_wdata_i[sel];
    end

    // The pointer only moves when a real contention was resolved by it;
    // lock-held grants and single-requester grants leave it alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q     <= 1'b0;
            last_grant_q <= 1'b0;
        end else if (accept) begin
            last_grant_q <= sel;
            if (!hold && (req_valid_i == 2'b11)) begin
                rr_ptr_q <= ~sel;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iss_valid_q <= 1'b0;
            iss_id_q    <= 1'b0;
            iss_legal_q <= 1'b0;
            iss_req_q   <= '0;
        end else begin
            iss_valid_q <= accept;
            // Address/data registers only load on accept so they hold their
            // last values while the stage is idle.
            if (accept) begin
                iss_id_q    <= sel;
                iss_legal_q <= is_legal(acc_req);
                iss_req_q   <= acc_req;
            end
        end
    end

    assign lsu_sten_o     = iss_valid_q & iss_req_q.we & iss_legal_q;
    assign lsu_byte_num_o = iss_req_q.byte_num;
    assign lsu_addr_o     = iss_req_q.addr;
    assign lsu_st_data_o  = iss_req_q.wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= iss_valid_q;
            if (iss_valid_q) begin
                rsp_q.id    <= iss_id_q;
                rsp_q.err   <= ~iss_legal_q;
                rsp_q.rdata <= (iss_legal_q && !iss_req_q.we) ? lsu_ld_data_i : '0;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_q.id;
    assign rsp_err_o   = rsp_q.err;
    assign rsp_rdata_o = rsp_q.rdata;

endmodule
